// File: rtl/shift_unit.sv
// shift_unit
// ----------
// WIDTH-bit storage register with load, clear and multi-cycle shift/rotate.
// Each shift or rotate moves the word by one bit position per clock. A caller
// requests an operation with Start. The unit reports its progress on Busy and
// Done.
//
// Handshake: Start is a one-sided request that is accepted only while the
// unit is in IDLE. The edge that accepts it also captures Op, Amt and D. A
// Start seen in SHIFT or DONE is dropped and is not remembered. Busy is high
// for the whole SHIFT phase. Done pulses for exactly one cycle when the
// result in Q is final. The next request can be accepted on the edge after
// that Done cycle.
//
// Ports:
//   Clock     in   rising-edge clock
//   Resetn    in   synchronous active-low reset (overrides everything)
//   Start     in   operation request, accepted only in IDLE
//   Op        in   [2:0] operation code, captured with Start
//   Amt       in   [AW-1:0] shift count, captured with Start
//   D         in   [WIDTH-1:0] parallel load data (LOAD)
//   SerIn     in   serial fill bit for SHL/SHR, sampled on every shift edge
//   Q         out  [WIDTH-1:0] register contents
//   SerOut    out  last bit shifted/rotated out (held between shifts)
//   Busy      out  high in SHIFT
//   Done      out  one-cycle completion pulse
//   dbg_state out  [1:0] current FSM state, for observation only
module shift_unit #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [AW-1:0]    Amt,
    input  logic [WIDTH-1:0] D,
    input  logic             SerIn,
    output logic [WIDTH-1:0] Q,
    output logic             SerOut,
    output logic             Busy,
    output logic             Done,
    output logic [1:0]       dbg_state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_CLEAR = 3'b010;
    localparam logic [2:0] OP_SHL   = 3'b011;
    localparam logic [2:0] OP_SHR   = 3'b100;
    localparam logic [2:0] OP_ROL   = 3'b101;
    localparam logic [2:0] OP_ROR   = 3'b110;
    localparam logic [2:0] OP_ASR   = 3'b111;

    localparam logic [AW-1:0] CNT_ZERO = '0;
    localparam logic [AW-1:0] CNT_ONE  = {{(AW-1){1'b0}}, 1'b1};

    logic [1:0]       state;
    logic [AW-1:0]    cnt;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] q_r;
    logic             ser_r;

    // One-position step of the captured operation. SerIn is used live here,
    // so the fill bit can change from one shift edge to the next.
    logic [WIDTH-1:0] step_q;
    logic             step_bit;

    always_comb begin
        step_q   = q_r;
        step_bit = ser_r;
        case (op_r)
            OP_SHL: begin
                step_q   = {q_r[WIDTH-2:0], SerIn};
                step_bit = q_r[WIDTH-1];
            end
            OP_SHR: begin
                step_q   = {SerIn, q_r[WIDTH-1:1]};
                step_bit = q_r[0];
            end
            OP_ROL: begin
                step_q   = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
                step_bit = q_r[WIDTH-1];
            end
            OP_ROR: begin
                step_q   = {q_r[0], q_r[WIDTH-1:1]};
                step_bit = q_r[0];
            end
            OP_ASR: begin
                step_q   = {q_r[WIDTH-1], q_r[WIDTH-1:1]};
                step_bit = q_r[0];
            end
            default: begin
                step_q   = q_r;
                step_bit = ser_r;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state <= S_IDLE;
            cnt   <= CNT_ZERO;
            op_r  <= OP_NOP;
            q_r   <= '0;
            ser_r <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        if (Op >= OP_SHL) begin
                            // A zero count finishes right away and leaves Q
                            // unchanged. Q is never touched on the capture edge.
                            if (Amt != CNT_ZERO) begin
                                op_r  <= Op;
                                cnt   <= Amt;
                                state <= S_SHIFT;
                            end else begin
                                state <= S_DONE;
                            end
                        end else begin
                            if (Op == OP_LOAD) begin
                                q_r <= D;
                            end else if (Op == OP_CLEAR) begin
                                q_r <= '0;
                            end
                            state <= S_DONE;
                        end
                    end
                end
                S_SHIFT: begin
                    q_r   <= step_q;
                    ser_r <= step_bit;
                    cnt   <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign Q         = q_r;
    assign SerOut    = ser_r;
    assign Busy      = (state == S_SHIFT);
    assign Done      = (state == S_DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_shift_unit.sv
module tb_shift_unit;

    localparam int W  = 8;
    localparam int AW = 4;

    // ---------------- clock / reset ----------------
    logic          clock;
    logic          resetn;
    logic          start;
    logic [2:0]    op;
    logic [AW-1:0] amt;
    logic [W-1:0]  d;
    logic          ser_in;
    logic [W-1:0]  q;
    logic          ser_out;
    logic          busy;
    logic          done;
    logic [1:0]    dbg_state;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    shift_unit #(.WIDTH(W), .AW(AW)) dut (
        .Clock    (clock),
        .Resetn   (resetn),
        .Start    (start),
        .Op       (op),
        .Amt      (amt),
        .D        (d),
        .SerIn    (ser_in),
        .Q        (q),
        .SerOut   (ser_out),
        .Busy     (busy),
        .Done     (done),
        .dbg_state(dbg_state)
    );

    // ---------------- scoreboard ----------------
    // Each entry is the expected {SerOut, Q} at the Done cycle of one operation.
    logic [W:0] exp_q[$];
    logic [W-1:0] m_q;
    logic         m_ser;
    int checks;
    int errors;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour. It is written from the operation table, one step
    // at a time. The fill bit is taken as constant for the whole operation.
    function automatic logic [W:0] model(input logic [2:0] o, input logic [AW-1:0] n,
                                         input logic [W-1:0] qi, input logic [W-1:0] di,
                                         input logic si, input logic sin);
        logic [W-1:0] r;
        logic         s;
        r = qi;
        s = si;
        case (o)
            3'd1: r = di;
            3'd2: r = '0;
            3'd0: r = qi;
            default: begin
                for (int i = 0; i < int'(n); i++) begin
                    case (o)
                        3'd3: begin s = r[W-1]; r = (r << 1) | W'(sin); end
                        3'd4: begin s = r[0];   r = (r >> 1) | ({W{sin}} & (W'(1) << (W-1))); end
                        3'd5: begin s = r[W-1]; r = (r << 1) | W'(r[W-1]); end
                        3'd6: begin s = r[0];   r = (r >> 1) | ({W{r[0]}} & (W'(1) << (W-1))); end
                        default: begin s = r[0]; r = $signed(r) >>> 1; end
                    endcase
                end
            end
        endcase
        return {s, r};
    endfunction

    // ---------------- driver ----------------
    // Called at a falling edge. It drives one request and follows it through
    // to the cycle after Done. That leaves the bench at the next falling edge,
    // so back-to-back calls issue a request every N+2 cycles.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [AW-1:0] n,
                          input logic [W-1:0] di, input logic sin, input bit poke_clear);
        logic [W:0]   exp;
        logic [W-1:0] q_before;
        int           busy_cnt;
        int           exp_busy;
        bit           seen_done;
        exp = model(o, n, m_q, di, m_ser, sin);
        exp_q.push_back(exp);
        m_q      = exp[W-1:0];
        m_ser    = exp[W];
        exp_busy = (o >= 3'd3) ? int'(n) : 0;
        q_before = q;
        start  = 1'b1;
        op     = o;
        amt    = n;
        d      = di;
        ser_in = sin;
        @(posedge clock);
        #1 start = 1'b0;
        busy_cnt  = 0;
        seen_done = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (done) begin
                seen_done = 1;
                break;
            end
            if (busy) begin
                busy_cnt++;
                if (busy_cnt == 1) check({tag, "_q_hold_on_capture"}, 32'(q), 32'(q_before));
                if (poke_clear && busy_cnt == 2) begin
                    start = 1'b1;
                    op    = 3'd2;
                    d     = 8'h00;
                end
                if (poke_clear && busy_cnt == 3) begin
                    start = 1'b0;
                    op    = o;
                end
            end
        end
        start = 1'b0;
        check({tag, "_done_seen"}, 32'(seen_done), 32'd1);
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
        exp = exp_q.pop_front();
        check({tag, "_q"}, 32'(q), 32'(exp[W-1:0]));
        check({tag, "_ser_out"}, 32'(ser_out), 32'(exp[W]));
        @(negedge clock);
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        checks = 0;
        errors = 0;
        m_q    = '0;
        m_ser  = 1'b0;
        resetn = 1'b0;
        start  = 1'b1;
        op     = 3'd1;
        amt    = '0;
        d      = 8'hFF;
        ser_in = 1'b0;

        // Reset wins over a pending LOAD request.
        @(posedge clock);
        @(negedge clock);
        check("rst_q", 32'(q), 32'h00);
        check("rst_ser_out", 32'(ser_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        start  = 1'b0;
        resetn = 1'b1;
        @(negedge clock);

        run_op("load_a5", 3'd1, 4'd0, 8'hA5, 1'b0, 0);
        run_op("nop", 3'd0, 4'd0, 8'h00, 1'b0, 0);
        run_op("rol3", 3'd5, 4'd3, 8'h00, 1'b0, 0);
        check("rol3_model_q", 32'(m_q), 32'h2D);
        run_op("load_90", 3'd1, 4'd0, 8'h90, 1'b0, 0);
        run_op("asr2", 3'd7, 4'd2, 8'h00, 1'b0, 0);
        check("asr2_model_q", 32'(m_q), 32'hE4);
        run_op("clear", 3'd2, 4'd0, 8'h00, 1'b0, 0);
        // A CLEAR request pulsed mid-shift must be ignored.
        run_op("shl9", 3'd3, 4'd9, 8'h00, 1'b1, 1);
        check("shl9_model_q", 32'(m_q), 32'hFF);

        // A reset in the middle of a shift aborts it with no Done.
        run_op("load_f0", 3'd1, 4'd0, 8'hF0, 1'b0, 0);
        start  = 1'b1;
        op     = 3'd4;
        amt    = 4'd5;
        ser_in = 1'b0;
        @(posedge clock);
        #1 start = 1'b0;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        check("shr_abort_mid_q", 32'(q), 32'h3C);
        check("shr_abort_mid_busy", 32'(busy), 32'd1);
        resetn = 1'b0;
        @(negedge clock);
        check("shr_abort_q", 32'(q), 32'h00);
        check("shr_abort_busy", 32'(busy), 32'd0);
        check("shr_abort_done", 32'(done), 32'd0);
        resetn = 1'b1;
        @(negedge clock);
        check("shr_abort_no_done", 32'(done), 32'd0);
        m_q   = '0;
        m_ser = 1'b0;
        run_op("load_3c", 3'd1, 4'd0, 8'h3C, 1'b0, 0);

        // Zero-count shift and back-to-back requests every two cycles.
        run_op("load_5a", 3'd1, 4'd0, 8'h5A, 1'b0, 0);
        run_op("shl0", 3'd3, 4'd0, 8'h00, 1'b1, 0);
        run_op("b2b_load", 3'd1, 4'd0, 8'hC3, 1'b0, 0);
        run_op("b2b_clear", 3'd2, 4'd0, 8'h00, 1'b0, 0);
        run_op("b2b_load2", 3'd1, 4'd0, 8'h81, 1'b0, 0);

        // Randomised shift/rotate operations from random starting words.
        for (int i = 0; i < 6; i++) begin
            run_op("rnd_load", 3'd1, 4'd0, 8'($urandom_range(0, 255)), 1'b0, 0);
            run_op("rnd_shift", 3'($urandom_range(3, 7)), 4'($urandom_range(0, 15)),
                   8'h00, 1'($urandom_range(0, 1)), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
